// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: loads a WIDTH-bit word on a one-cycle load strobe and
// shifts it out MSB first on d, holding each bit for HOLD clocks.
// Ports: clock, reset (sync, active-high), load, data[WIDTH-1:0] in;
//        ready (idle), d (serial bit), valid (d is payload), done (end pulse) out.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             d,
  output logic             valid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;

  // sreg[WIDTH-1] is always the bit currently on d; the next bit to
  // present is therefore sreg[WIDTH-2] before the shift takes effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      d        <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
      sreg     <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            state    <= SHIFT;
            sreg     <= data;
            d        <= data[WIDTH-1];
            valid    <= 1'b1;
            ready    <= 1'b0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
          end
        end
        SHIFT: begin
          if (hold_cnt == HLAST) begin
            hold_cnt <= '0;
            if (bit_cnt == BLAST) begin
              state   <= DONE;
              done    <= 1'b1;
              valid   <= 1'b0;
              d       <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sreg    <= {sreg[WIDTH-2:0], 1'b0};
              d       <= sreg[WIDTH-2];
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          sreg  <= '0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          d     <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed bench for serial_pattern_tx with HOLD=1
// and HOLD=2 instances; expected per-cycle outputs are queued at load time.
module tb_serial_pattern_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load1 = 1'b0;
  logic       load2 = 1'b0;
  logic [7:0] data  = 8'h00;

  logic ready1, d1, valid1, done1;
  logic ready2, d2, valid2, done2;

  int nchk = 0;
  int nerr = 0;
  int cycno = 0;

  // entries are {ready, d, valid, done} for one cycle
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic       m1_rdy = 1'b0;
  logic       m2_rdy = 1'b0;
  logic       m1_done = 1'b0;

  always #5 clock = ~clock;

  serial_pattern_tx #(.WIDTH(8), .HOLD(1)) u1 (
    .clock(clock), .reset(reset), .load(load1), .data(data),
    .ready(ready1), .d(d1), .valid(valid1), .done(done1)
  );

  serial_pattern_tx #(.WIDTH(8), .HOLD(2)) u2 (
    .clock(clock), .reset(reset), .load(load2), .data(data),
    .ready(ready2), .d(d2), .valid(valid2), .done(done2)
  );

  task automatic ld1(input logic [7:0] w);
    load1 = 1'b1;
    data  = w;
    if (m1_rdy && !reset) begin
      for (int i = 7; i >= 0; i--) q1.push_back({1'b0, w[i], 2'b10});
      q1.push_back(4'b0001);
    end
  endtask

  task automatic ld2(input logic [7:0] w);
    load2 = 1'b1;
    data  = w;
    if (m2_rdy && !reset) begin
      for (int i = 7; i >= 0; i--) begin
        q2.push_back({1'b0, w[i], 2'b10});
        q2.push_back({1'b0, w[i], 2'b10});
      end
      q2.push_back(4'b0001);
    end
  endtask

  task automatic cyc();
    logic       rst_now;
    logic [3:0] e1, e2, o1, o2;
    rst_now = reset;
    @(posedge clock);
    #1;
    cycno++;
    if (rst_now) begin
      q1.delete();
      q2.delete();
    end
    e1 = (q1.size() > 0) ? q1.pop_front() : 4'b1000;
    e2 = (q2.size() > 0) ? q2.pop_front() : 4'b1000;
    o1 = {ready1, d1, valid1, done1};
    o2 = {ready2, d2, valid2, done2};
    nchk++;
    assert (o1 === e1) else begin
      nerr++;
      $error("FAIL h1 cyc %0d rdy/d/vld/done obs=%b exp=%b", cycno, o1, e1);
    end
    nchk++;
    assert (o2 === e2) else begin
      nerr++;
      $error("FAIL h2 cyc %0d rdy/d/vld/done obs=%b exp=%b", cycno, o2, e2);
    end
    m1_rdy  = e1[3];
    m2_rdy  = e2[3];
    m1_done = e1[0];
    load1 = 1'b0;
    load2 = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_ready();
    int n;
    n = 0;
    cyc();
    while (!(m1_rdy && m2_rdy) && n < 100) begin
      cyc();
      n++;
    end
    nchk++;
    assert (n < 100) else begin
      nerr++;
      $error("FAIL ready_timeout obs=%0d exp<100", n);
    end
  endtask

  task automatic run_done1();
    int n;
    n = 0;
    while (!m1_done && n < 100) begin
      cyc();
      n++;
    end
    nchk++;
    assert (n < 100) else begin
      nerr++;
      $error("FAIL done_timeout obs=%0d exp<100", n);
    end
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    cyc();
    cyc();

    // 1: HOLD=1, 8'hB2
    ld1(8'hB2);
    run_ready();
    cyc();

    // 2: HOLD=2, 8'hB2
    ld2(8'hB2);
    run_ready();
    cyc();

    // 3: load during shift and in done cycle ignored, then back-to-back
    ld1(8'hB2);
    cyc();
    cyc();
    cyc();
    ld1(8'hFF);
    cyc();
    run_done1();
    ld1(8'h5A);
    cyc();
    ld1(8'h5A);
    run_ready();
    cyc();

    // 4: reset mid-word aborts, then a clean word
    ld1(8'hFF);
    cyc();
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    repeat (10) cyc();
    ld1(8'h81);
    run_ready();

    // 5: all-zero word, then load together with reset
    ld1(8'h00);
    run_ready();
    reset = 1'b1;
    ld1(8'h5A);
    ld2(8'h5A);
    cyc();
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
